// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ready/read-data back.
// Valid/ready: a fetch transfers in any cycle with imem_req & imem_ready; imem_addr is held while imem_req & !imem_ready.
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [PC_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: sequential fetch, branch target
// generation, next-address select and redirect with squash of an outstanding fetch.
module pc_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        BS,
    input  logic              PS,
    input  logic              Z,
    input  logic [PC_W-1:0]   disp,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic [PC_W-1:0]   output_muxc,
    output logic [2*PC_W-1:0] BrA,
    output logic [1:0]        output_lgate,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_1,
    output logic [PC_W-1:0]   ir,
    output logic              ir_valid,
    output logic [1:0]        fsm_state,
    pc_sequencer_if.master    imem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HOLD   = 2'd2,
        S_SQUASH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_d, pc_1_d, ir_d, save_q, save_d;
    logic            ir_valid_d;
    logic [1:0]      sel;
    logic            redirect;

    always_comb begin
        sel = 2'b00;
        case (BS)
            2'b01:   sel = (Z ^ PS) ? 2'b01 : 2'b00;
            2'b10:   sel = 2'b10;
            2'b11:   sel = 2'b11;
            default: sel = 2'b00;
        endcase
    end

    assign output_lgate   = ir_valid ? sel : 2'b00;
    assign redirect       = ir_valid && (output_lgate != 2'b00) && !stall;
    assign BrA            = {jmp_target, pc_1 + PC_W'(1) + disp};
    assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_SQUASH);
    assign imem.imem_addr = pc;
    assign fsm_state      = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        pc_1_d     = pc_1;
        ir_d       = ir;
        ir_valid_d = ir_valid;
        save_d     = save_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (stall) begin
                    state_d = S_HOLD;
                end else if (redirect) begin
                    ir_valid_d = 1'b0;
                    // An unaccepted fetch must keep its address, so park the target.
                    if (imem.imem_ready) begin
                        pc_d = output_muxc;
                    end else begin
                        save_d  = output_muxc;
                        state_d = S_SQUASH;
                    end
                end else if (imem.imem_ready) begin
                    ir_d       = imem.imem_rdata;
                    ir_valid_d = 1'b1;
                    pc_1_d     = pc;
                    pc_d       = pc + PC_W'(1);
                end else begin
                    ir_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    if (redirect) begin
                        pc_d       = output_muxc;
                        ir_valid_d = 1'b0;
                    end
                end
            end
            S_SQUASH: begin
                ir_valid_d = 1'b0;
                if (imem.imem_ready) begin
                    pc_d    = save_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc       <= RESET_PC;
            pc_1     <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            save_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            pc_1     <= pc_1_d;
            ir       <= ir_d;
            ir_valid <= ir_valid_d;
            save_q   <= save_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: memory returns addr+100, the bench plays the next-address mux.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, stall;
    logic [1:0]  BS;
    logic        PS, Z;
    logic [31:0] disp, jmp_target, output_muxc;
    logic [63:0] BrA;
    logic [1:0]  output_lgate, fsm_state;
    logic [31:0] pc, pc_1, ir;
    logic        ir_valid;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(32)) imem_bus ();
    assign imem_bus.imem_rdata = imem_bus.imem_addr + 32'd100;

    pc_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .BS           (BS),
        .PS           (PS),
        .Z            (Z),
        .disp         (disp),
        .jmp_target   (jmp_target),
        .output_muxc  (output_muxc),
        .BrA          (BrA),
        .output_lgate (output_lgate),
        .pc           (pc),
        .pc_1         (pc_1),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .fsm_state    (fsm_state),
        .imem         (imem_bus.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; BS = 2'b00; PS = 1'b0; Z = 1'b0;
        disp = '0; jmp_target = '0; output_muxc = '0;
        imem_bus.imem_ready = 1'b1;
        step(); step();
        check("rst_pc",       64'(pc), 64'(0));
        check("rst_pc_1",     64'(pc_1), 64'(0));
        check("rst_ir",       64'(ir), 64'(0));
        check("rst_ir_valid", 64'(ir_valid), 64'(0));
        check("rst_req",      64'(imem_bus.imem_req), 64'(0));
        check("rst_lgate",    64'(output_lgate), 64'(0));
        check("rst_state",    64'(fsm_state), 64'(0));

        // Sequential stream
        reset = 1'b0;
        step();
        check("first_req",  64'(imem_bus.imem_req), 64'(1));
        check("first_addr", 64'(imem_bus.imem_addr), 64'(0));
        step();
        check("seq_ir0",    64'(ir), 64'(100));
        check("seq_v0",     64'(ir_valid), 64'(1));
        check("seq_pc1_0",  64'(pc_1), 64'(0));
        check("seq_addr1",  64'(imem_bus.imem_addr), 64'(1));
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_pc1",  64'(pc_1), 64'(i));
            check("seq_ir",   64'(ir), 64'(100 + i));
            check("seq_addr", 64'(imem_bus.imem_addr), 64'(i + 1));
        end

        // Taken conditional branch at pc_1=5, disp=-3
        BS = 2'b01; PS = 1'b0; Z = 1'b1; disp = 32'hFFFF_FFFD; output_muxc = 32'd3;
        #1;
        check("cond_bra",   64'(BrA[31:0]), 64'(3));
        check("cond_lgate", 64'(output_lgate), 64'(1));
        step();
        BS = 2'b00;
        check("cond_bubble", 64'(ir_valid), 64'(0));
        check("cond_addr",   64'(imem_bus.imem_addr), 64'(3));
        check("cond_req",    64'(imem_bus.imem_req), 64'(1));
        step();
        check("cond_ir",  64'(ir), 64'(103));
        check("cond_pc1", 64'(pc_1), 64'(3));
        check("cond_v",   64'(ir_valid), 64'(1));
        step(); step();
        check("nt_pc1",  64'(pc_1), 64'(5));
        check("nt_addr", 64'(imem_bus.imem_addr), 64'(6));

        // Same branch, not taken
        BS = 2'b01; Z = 1'b0;
        #1;
        check("nt_lgate", 64'(output_lgate), 64'(0));
        step();
        BS = 2'b00;
        check("nt_ir",    64'(ir), 64'(106));
        check("nt_v",     64'(ir_valid), 64'(1));
        check("nt_pc1_6", 64'(pc_1), 64'(6));
        check("nt_addr7", 64'(imem_bus.imem_addr), 64'(7));

        // Absolute jump with fetch of 7 outstanding and unaccepted
        BS = 2'b11; jmp_target = 32'h40; output_muxc = 32'h40; disp = 32'd10;
        imem_bus.imem_ready = 1'b0;
        #1;
        check("jmp_lgate", 64'(output_lgate), 64'(3));
        check("jmp_bra",   BrA, 64'h0000_0040_0000_0011);
        step();
        BS = 2'b00; output_muxc = 32'h99;
        check("sq_state", 64'(fsm_state), 64'(3));
        check("sq_req",   64'(imem_bus.imem_req), 64'(1));
        check("sq_addr",  64'(imem_bus.imem_addr), 64'(7));
        check("sq_v",     64'(ir_valid), 64'(0));
        step();
        check("sq_addr2", 64'(imem_bus.imem_addr), 64'(7));
        check("sq_v2",    64'(ir_valid), 64'(0));
        imem_bus.imem_ready = 1'b1;
        step();
        check("sq_drop_ir", 64'(ir), 64'(106));
        check("sq_drop_v",  64'(ir_valid), 64'(0));
        check("sq_tgt",     64'(imem_bus.imem_addr), 64'(32'h40));
        check("sq_fetch",   64'(fsm_state), 64'(1));
        step();
        check("jmp_ir",  64'(ir), 64'(32'hA4));
        check("jmp_v",   64'(ir_valid), 64'(1));
        check("jmp_pc1", 64'(pc_1), 64'(32'h40));

        // Two-cycle stall
        stall = 1'b1;
        step();
        check("st_req1", 64'(imem_bus.imem_req), 64'(0));
        check("st_ir1",  64'(ir), 64'(32'hA4));
        check("st_pc1",  64'(pc_1), 64'(32'h40));
        step();
        check("st_req2", 64'(imem_bus.imem_req), 64'(0));
        check("st_pc",   64'(pc), 64'(32'h41));
        check("st_v",    64'(ir_valid), 64'(1));
        stall = 1'b0;
        step();
        check("st_resume_req",  64'(imem_bus.imem_req), 64'(1));
        check("st_resume_addr", 64'(imem_bus.imem_addr), 64'(32'h41));
        step();
        check("st_resume_ir", 64'(ir), 64'(32'hA5));

        // Stall beats redirect; redirect taken once stall drops; PC wrap
        BS = 2'b10; output_muxc = 32'hFFFF_FFFF; stall = 1'b1;
        #1;
        check("sr_lgate", 64'(output_lgate), 64'(2));
        step();
        check("sr_pc_held", 64'(pc), 64'(32'h42));
        check("sr_v_held",  64'(ir_valid), 64'(1));
        stall = 1'b0;
        step();
        BS = 2'b00;
        check("sr_addr", 64'(imem_bus.imem_addr), 64'(32'hFFFF_FFFF));
        check("sr_v",    64'(ir_valid), 64'(0));
        step();
        disp = '0;
        #1;
        check("wrap_ir",   64'(ir), 64'(32'h63));
        check("wrap_pc1",  64'(pc_1), 64'(32'hFFFF_FFFF));
        check("wrap_addr", 64'(imem_bus.imem_addr), 64'(0));
        check("wrap_bra",  64'(BrA[31:0]), 64'(0));

        // Reset while a request waits
        step();
        check("rq_addr", 64'(imem_bus.imem_addr), 64'(1));
        imem_bus.imem_ready = 1'b0;
        step();
        check("rq_hold_addr", 64'(imem_bus.imem_addr), 64'(1));
        check("rq_hold_req",  64'(imem_bus.imem_req), 64'(1));
        reset = 1'b1;
        step();
        check("rq_rst_req",   64'(imem_bus.imem_req), 64'(0));
        check("rq_rst_pc",    64'(pc), 64'(0));
        check("rq_rst_v",     64'(ir_valid), 64'(0));
        check("rq_rst_state", 64'(fsm_state), 64'(0));
        reset = 1'b0; imem_bus.imem_ready = 1'b1;
        step();
        check("rq_restart", 64'(imem_bus.imem_req), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
